// File: rtl/traffic_light_monitor.sv
// Receive-side monitor for the traffic light controller: registered lamp decode,
// per-phase dwell measurement, sequence/dwell checking, cycle counting and error flags.
module traffic_light_monitor #(
  parameter int GREEN_CYCLES  = 21,
  parameter int YELLOW_CYCLES = 6,
  parameter int RED_CYCLES    = 16,
  parameter int CNT_W         = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state_in,
  input  logic             clear_err,
  output logic             lamp_green,
  output logic             lamp_yellow,
  output logic             lamp_red,
  output logic             phase_change,
  output logic [CNT_W-1:0] dwell_last,
  output logic [15:0]      cycle_count,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             err_code,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    PH_ILL    = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_RED    = 2'b11
  } phase_t;

  function automatic logic [CNT_W-1:0] expected(input phase_t p);
    case (p)
      PH_GREEN:  expected = CNT_W'(GREEN_CYCLES);
      PH_YELLOW: expected = CNT_W'(YELLOW_CYCLES);
      PH_RED:    expected = CNT_W'(RED_CYCLES);
      default:   expected = '0;
    endcase
  endfunction

  phase_t           cur_phase, cur_phase_n, in_phase;
  logic [CNT_W-1:0] dwell, dwell_n, dwell_last_n, exp_dwell;
  logic             reported, reported_n;
  logic             phase_change_n, err_seq_n, err_dwell_n, err_code_n, err_sticky_n;
  logic [15:0]      cycle_count_n;
  logic             legal_succ;

  assign in_phase  = phase_t'(state_in);
  assign exp_dwell = expected(cur_phase);
  assign legal_succ = (cur_phase == PH_GREEN  && in_phase == PH_YELLOW) ||
                      (cur_phase == PH_YELLOW && in_phase == PH_RED)    ||
                      (cur_phase == PH_RED    && in_phase == PH_GREEN);

  always_comb begin
    cur_phase_n    = cur_phase;
    dwell_n        = dwell;
    reported_n     = reported;
    dwell_last_n   = dwell_last;
    cycle_count_n  = cycle_count;
    phase_change_n = 1'b0;
    err_seq_n      = 1'b0;
    err_dwell_n    = 1'b0;
    err_code_n     = 1'b0;
    if (in_phase == PH_ILL) begin
      // Illegal code freezes the measurement; only the code error fires.
      err_code_n = 1'b1;
    end else if (in_phase == cur_phase) begin
      if (dwell != '1) dwell_n = dwell + CNT_W'(1);
      // Overstay is flagged once, the edge the count passes the expected dwell.
      if (!reported && dwell == exp_dwell) begin
        err_dwell_n = 1'b1;
        reported_n  = 1'b1;
      end
    end else begin
      phase_change_n = 1'b1;
      dwell_last_n   = dwell;
      err_seq_n      = !legal_succ;
      err_dwell_n    = !reported && (dwell != exp_dwell);
      if (legal_succ && cur_phase == PH_RED) cycle_count_n = cycle_count + 16'd1;
      cur_phase_n    = in_phase;
      dwell_n        = CNT_W'(1);
      reported_n     = 1'b0;
    end
    // A fresh error outranks a simultaneous clear.
    err_sticky_n = err_seq_n | err_dwell_n | err_code_n | (err_sticky & ~clear_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_phase    <= PH_GREEN;
      dwell        <= '0;
      reported     <= 1'b0;
      lamp_green   <= 1'b1;
      lamp_yellow  <= 1'b0;
      lamp_red     <= 1'b0;
      phase_change <= 1'b0;
      dwell_last   <= '0;
      cycle_count  <= '0;
      err_seq      <= 1'b0;
      err_dwell    <= 1'b0;
      err_code     <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      cur_phase    <= cur_phase_n;
      dwell        <= dwell_n;
      reported     <= reported_n;
      lamp_green   <= (state_in == 2'b01);
      lamp_yellow  <= (state_in == 2'b10);
      lamp_red     <= (state_in == 2'b11);
      phase_change <= phase_change_n;
      dwell_last   <= dwell_last_n;
      cycle_count  <= cycle_count_n;
      err_seq      <= err_seq_n;
      err_dwell    <= err_dwell_n;
      err_code     <= err_code_n;
      err_sticky   <= err_sticky_n;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: stimulus queues hand-computed expected events; a negedge monitor
// pops one per phase_change/error pulse. Lamps and sticky flag are checked inline.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state_in;
  logic        clear_err;
  logic        lamp_green, lamp_yellow, lamp_red;
  logic        phase_change;
  logic [5:0]  dwell_last;
  logic [15:0] cycle_count;
  logic        err_seq, err_dwell, err_code, err_sticky;

  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .state_in(state_in), .clear_err(clear_err),
    .lamp_green(lamp_green), .lamp_yellow(lamp_yellow), .lamp_red(lamp_red),
    .phase_change(phase_change), .dwell_last(dwell_last), .cycle_count(cycle_count),
    .err_seq(err_seq), .err_dwell(err_dwell), .err_code(err_code), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc;
    logic [5:0]  dl;
    logic [15:0] cc;
    logic        es, ed, ec, st;
  } ev_t;

  ev_t q[$];
  int  passed = 0;
  int  total  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic push(input logic pc, input int dl, input int cc,
                      input logic es, input logic ed, input logic ec, input logic st);
    q.push_back('{pc, 6'(dl), 16'(cc), es, ed, ec, st});
  endtask

  // Event monitor, decoupled from stimulus.
  always @(negedge clk) begin
    if (!rst && (phase_change || err_seq || err_dwell || err_code)) begin
      ev_t got, want;
      got = '{phase_change, dwell_last, cycle_count, err_seq, err_dwell, err_code, err_sticky};
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event: got pc=%0b dl=%0d cc=%0d es=%0b ed=%0b ec=%0b st=%0b, none expected",
                 got.pc, got.dl, got.cc, got.es, got.ed, got.ec, got.st);
      end else begin
        want = q.pop_front();
        if (got === want) passed++;
        else $display("FAIL event: got pc=%0b dl=%0d cc=%0d es=%0b ed=%0b ec=%0b st=%0b expected pc=%0b dl=%0d cc=%0d es=%0b ed=%0b ec=%0b st=%0b",
                      got.pc, got.dl, got.cc, got.es, got.ed, got.ec, got.st,
                      want.pc, want.dl, want.cc, want.es, want.ed, want.ec, want.st);
      end
    end
  end

  function automatic logic [2:0] lamps_for(input logic [1:0] v);
    case (v)
      2'b01:   lamps_for = 3'b100;
      2'b10:   lamps_for = 3'b010;
      2'b11:   lamps_for = 3'b001;
      default: lamps_for = 3'b000;
    endcase
  endfunction

  task automatic step(input logic [1:0] v, input logic clr);
    state_in  = v;
    clear_err = clr;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
    chk("lamps", {29'd0, lamp_green, lamp_yellow, lamp_red}, {29'd0, lamps_for(v)});
  endtask

  task automatic drive(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  task automatic chk_reset_outputs();
    chk("reset_lamps", {29'd0, lamp_green, lamp_yellow, lamp_red}, 32'b100);
    chk("reset_pulses", {28'd0, phase_change, err_seq, err_dwell, err_code}, 32'd0);
    chk("reset_dwell_last", {26'd0, dwell_last}, 32'd0);
    chk("reset_cycle_count", {16'd0, cycle_count}, 32'd0);
    chk("reset_sticky", {31'd0, err_sticky}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; state_in = 2'b01; clear_err = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Nominal cycle
    push(1, 21, 0, 0, 0, 0, 0);
    push(1, 6,  0, 0, 0, 0, 0);
    push(1, 16, 1, 0, 0, 0, 0);
    drive(2'b01, 21); drive(2'b10, 6); drive(2'b11, 16); drive(2'b01, 1);

    // Short green (10 samples), then recover through a nominal cycle
    push(1, 10, 1, 0, 1, 0, 1);
    drive(2'b01, 9); drive(2'b10, 1);
    push(1, 6,  1, 0, 0, 0, 1);
    push(1, 16, 2, 0, 0, 0, 1);
    drive(2'b10, 5); drive(2'b11, 16); drive(2'b01, 1);
    step(2'b01, 1'b1);
    chk("clear_after_short", {31'd0, err_sticky}, 32'd0);

    // Skipped yellow: green->red, cycle_count must not move on the illegal hop
    push(1, 21, 2, 1, 0, 0, 1);
    drive(2'b01, 19); drive(2'b11, 1);
    push(1, 16, 3, 0, 0, 0, 1);
    drive(2'b11, 15); drive(2'b01, 1);
    step(2'b01, 1'b1);
    chk("clear_after_skip", {31'd0, err_sticky}, 32'd0);

    // Stuck green for 40 samples: one overstay pulse, none at the exit
    push(0, 16, 3, 0, 1, 0, 1);
    push(1, 40, 3, 0, 0, 0, 1);
    drive(2'b01, 38); drive(2'b10, 1);
    push(1, 6,  3, 0, 0, 0, 1);
    push(1, 16, 4, 0, 0, 0, 1);
    drive(2'b10, 5); drive(2'b11, 16); drive(2'b01, 1);
    step(2'b01, 1'b1);
    chk("clear_after_stuck", {31'd0, err_sticky}, 32'd0);

    // Illegal code during green: 19 green samples + 2 frozen cycles
    push(0, 16, 4, 0, 0, 1, 1);
    push(0, 16, 4, 0, 0, 1, 1);
    push(1, 19, 4, 0, 1, 0, 1);
    drive(2'b01, 10); drive(2'b00, 2); drive(2'b01, 7); drive(2'b10, 1);

    // Clear coinciding with err_seq (yellow->green), then clear alone
    push(1, 6, 4, 1, 0, 0, 1);
    drive(2'b10, 5);
    step(2'b01, 1'b1);
    chk("clear_loses_to_error", {31'd0, err_sticky}, 32'd1);
    step(2'b01, 1'b1);
    chk("clear_alone", {31'd0, err_sticky}, 32'd0);

    // Async reset mid-yellow, then restart aligned to green
    push(1, 21, 4, 0, 0, 0, 0);
    drive(2'b01, 19); drive(2'b10, 3);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs();
    chk("queue_drained_before_reset", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(1, 21, 0, 0, 0, 0, 0);
    drive(2'b01, 21); drive(2'b10, 1);
    @(negedge clk);
    #1;
    chk("queue_drained_at_end", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
